// File: rtl/out_channel_pkg.sv
// Shared types for the out-channel drain.
// Contents: the channel word type, the drain state type and its encoding constants.
package out_channel_pkg;

  localparam int unsigned MemoryElementWidth = 12;

  typedef logic [MemoryElementWidth-1:0] word_t;

  // Fixed encodings so the state can be read from a waveform or a legacy register map.
  localparam logic [1:0] STATE_RUN   = 2'd0;
  localparam logic [1:0] STATE_FLUSH = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  typedef enum logic [1:0] {
    RUN   = STATE_RUN,
    FLUSH = STATE_FLUSH,
    DONE  = STATE_DONE
  } drain_state_t;

endpackage

// File: rtl/out_channel_drain_if.sv
// Handshake bundle between the machine/host side and the drain.
//   out_valid/out_data/out_ready    : machine -> drain word channel
//   host_valid/host_data/host_ready : drain -> host show-ahead read channel
// The master modport belongs to the environment (machine and host), and the slave modport belongs to the drain.
interface out_channel_drain_if
  import out_channel_pkg::*;
();
  logic  out_valid;
  word_t out_data;
  logic  out_ready;
  logic  host_valid;
  word_t host_data;
  logic  host_ready;

  modport master (output out_valid, out_data, host_ready,
                  input  out_ready, host_valid, host_data);
  modport slave  (input  out_valid, out_data, host_ready,
                  output out_ready, host_valid, host_data);
endinterface

// File: rtl/out_channel_fifo.sv
// Circular word buffer with show-ahead read and non-power-of-two depth.
//   clock, reset  : posedge clock, async active-high reset
//   push/wr_data  : write one word (the caller guarantees !full)
//   pop           : retire rd_data (the caller guarantees !empty)
//   rd_data       : oldest stored word
//   full, empty, count : occupancy
module out_channel_fifo
  import out_channel_pkg::*;
#(
  parameter int unsigned Depth = 100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  word_t                      wr_data,
  output word_t                      rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  word_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // The pointers wrap explicitly because Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next-state logic for the pointers and the occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage array has no reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/out_channel_drain.sv
// Consumer end of a test program's out channel.
// This module buffers words from the machine, presents them to the host, and reports completion and success.
//   clock, reset   : posedge clock, async active-high reset
//   ch (slave)     : out_* word channel from the machine and host_* read channel to the host
//   prog_finished  : machine halted (level; only its first assertion in RUN counts)
//   words_total    : words accepted since reset (saturating)
//   overflow       : sticky, the machine offered a word while the buffer was full in RUN
//   finished       : the program has finished and the buffer is drained
//   success        : the program passed (meaningful only while finished=1)
// Optional macro OUT_CHANNEL_COMPARE_EN adds the ports exp_index, exp_data, mismatch and first_bad.
// With it, each accepted word is checked against a host-supplied expected word.
module out_channel_drain
  import out_channel_pkg::*;
#(
  parameter int unsigned NOut          = 100,
  parameter int unsigned ExpectedCount = 1,
  parameter int unsigned CountWidth    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  out_channel_drain_if.slave    ch,
  input  logic                  prog_finished,
  output logic [CountWidth-1:0] words_total,
  output logic                  overflow,
  output logic                  finished,
  output logic                  success
`ifdef OUT_CHANNEL_COMPARE_EN
  ,
  output logic [CountWidth-1:0] exp_index,
  input  word_t                 exp_data,
  output logic                  mismatch,
  output logic [CountWidth-1:0] first_bad
`endif
);
  localparam int unsigned CntW = $clog2(NOut + 1);

  drain_state_t          state_q, state_d;
  logic [CountWidth-1:0] words_total_q, words_total_d;
  logic                  overflow_q, overflow_d;
  logic                  finished_q, finished_d;
  logic                  success_q, success_d;
  logic                  fifo_full, fifo_empty;
  logic [CntW-1:0]       fifo_count;
  word_t                 fifo_rd_data;
  logic                  push, pop;
  logic                  cmp_ok;

  assign ch.out_ready  = (state_q == RUN) && !fifo_full;
  assign ch.host_valid = !fifo_empty;
  assign ch.host_data  = fifo_rd_data;
  assign push          = ch.out_valid && ch.out_ready;
  assign pop           = ch.host_valid && ch.host_ready;

  out_channel_fifo #(.Depth(NOut)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (ch.out_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef OUT_CHANNEL_COMPARE_EN
  logic                  mismatch_q, mismatch_d;
  logic [CountWidth-1:0] first_bad_q, first_bad_d;

  // Check each accepted word, and keep the index of the first word that differs.
  always_comb begin
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
    if (push && (ch.out_data != exp_data)) begin
      mismatch_d = 1'b1;
      if (!mismatch_q) first_bad_d = words_total_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else begin
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign exp_index = words_total_q;
  assign mismatch  = mismatch_q;
  assign first_bad = first_bad_q;
  assign cmp_ok    = !mismatch_d;
`else
  assign cmp_ok    = 1'b1;
`endif

  // Drain FSM, counters and status flags.
  always_comb begin
    state_d       = state_q;
    words_total_d = words_total_q;
    overflow_d    = overflow_q;
    finished_d    = finished_q;
    success_d     = success_q;

    if (push && (words_total_q != '1)) words_total_d = words_total_q + CountWidth'(1);
    if ((state_q == RUN) && ch.out_valid && fifo_full) overflow_d = 1'b1;

    case (state_q)
      RUN:     if (prog_finished) state_d = FLUSH;
      // No pushes happen in FLUSH, so the buffer empties when it is already empty or its last word is popped.
      FLUSH:   if (fifo_empty || ((fifo_count == CntW'(1)) && pop)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase

    // The verdict is captured once on entry to DONE and then held until reset.
    if ((state_d == DONE) && (state_q != DONE)) begin
      finished_d = 1'b1;
      success_d  = (words_total_d == CountWidth'(ExpectedCount)) && !overflow_d && cmp_ok;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      words_total_q <= '0;
      overflow_q    <= 1'b0;
      finished_q    <= 1'b0;
      success_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      words_total_q <= words_total_d;
      overflow_q    <= overflow_d;
      finished_q    <= finished_d;
      success_q     <= success_d;
    end
  end

  assign words_total = words_total_q;
  assign overflow    = overflow_q;
  assign finished    = finished_q;
  assign success     = success_q;

endmodule

// File: tb/tb_out_channel_drain.sv
// Directed bench for out_channel_drain using three instances.
//   dut_a : default parameters, used for the vector table and the compare feature
//   dut_b : NOut=4 and ExpectedCount=2, used for the full/overflow and drain sequences
//   dut_c : NOut=3, used for the wrap sequence against a queue model
module tb_out_channel_drain;
  import out_channel_pkg::*;

  localparam int unsigned CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  out_channel_drain_if ifa ();
  out_channel_drain_if ifb ();
  out_channel_drain_if ifc ();

  logic          pf_a, pf_b, pf_c;
  logic [CW-1:0] wt_a, wt_b, wt_c;
  logic          ovf_a, ovf_b, ovf_c;
  logic          fin_a, fin_b, fin_c;
  logic          suc_a, suc_b, suc_c;

`ifdef OUT_CHANNEL_COMPARE_EN
  logic [CW-1:0] ei_a, ei_b, ei_c, fb_a, fb_b, fb_c;
  logic          mm_a, mm_b, mm_c;
  word_t         exp_data_a;
`endif

  out_channel_drain #(.NOut(100), .ExpectedCount(1), .CountWidth(CW)) dut_a (
    .clock(clock), .reset(reset), .ch(ifa.slave), .prog_finished(pf_a),
    .words_total(wt_a), .overflow(ovf_a), .finished(fin_a), .success(suc_a)
`ifdef OUT_CHANNEL_COMPARE_EN
    , .exp_index(ei_a), .exp_data(exp_data_a), .mismatch(mm_a), .first_bad(fb_a)
`endif
  );

  out_channel_drain #(.NOut(4), .ExpectedCount(2), .CountWidth(CW)) dut_b (
    .clock(clock), .reset(reset), .ch(ifb.slave), .prog_finished(pf_b),
    .words_total(wt_b), .overflow(ovf_b), .finished(fin_b), .success(suc_b)
`ifdef OUT_CHANNEL_COMPARE_EN
    , .exp_index(ei_b), .exp_data(ifb.out_data), .mismatch(mm_b), .first_bad(fb_b)
`endif
  );

  out_channel_drain #(.NOut(3), .ExpectedCount(1), .CountWidth(CW)) dut_c (
    .clock(clock), .reset(reset), .ch(ifc.slave), .prog_finished(pf_c),
    .words_total(wt_c), .overflow(ovf_c), .finished(fin_c), .success(suc_c)
`ifdef OUT_CHANNEL_COMPARE_EN
    , .exp_index(ei_c), .exp_data(ifc.out_data), .mismatch(mm_c), .first_bad(fb_c)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge and settle, so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  typedef struct {
    bit    rst;
    logic  ov;
    word_t od;
    logic  hr;
    logic  pf;
    logic  e_ordy;
    logic  e_hv;
    bit    chk_hd;
    word_t e_hd;
    int    e_wt;
    logic  e_ovf;
    logic  e_fin;
    logic  e_suc;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  word_t model_q [$];
  int    m_wt;
  logic  m_ovf;
  bit    do_push, do_pop;

  initial begin
    // Fields: rst ov od hr pf | ordy hv chk_hd hd wt ovf fin suc
    // Push 10, 20 and 30 back to back while the host pops every cycle.
    vt[0]  = '{0, 1, 10, 1, 0,  1, 1, 1, 10, 1, 0, 0, 0};
    vt[1]  = '{0, 1, 20, 1, 0,  1, 1, 1, 20, 2, 0, 0, 0};
    vt[2]  = '{0, 1, 30, 1, 0,  1, 1, 1, 30, 3, 0, 0, 0};
    vt[3]  = '{0, 0,  0, 1, 0,  1, 0, 0,  0, 3, 0, 0, 0};
    // Finish with an empty buffer. Three words against an expected count of 1 must fail.
    vt[4]  = '{0, 0,  0, 0, 1,  0, 0, 0,  0, 3, 0, 0, 0};
    vt[5]  = '{0, 0,  0, 0, 0,  0, 0, 0,  0, 3, 0, 1, 0};
    vt[6]  = '{0, 1,  5, 0, 0,  0, 0, 0,  0, 3, 0, 1, 0};
    // After a reset, one word then finish and drain must pass.
    vt[7]  = '{1, 1, 42, 0, 0,  1, 1, 1, 42, 1, 0, 0, 0};
    vt[8]  = '{0, 0,  0, 0, 1,  0, 1, 1, 42, 1, 0, 0, 0};
    vt[9]  = '{0, 0,  0, 1, 0,  0, 0, 0,  0, 1, 0, 1, 1};
    vt[10] = '{0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 1, 1};

    ifa.out_valid = 0; ifa.out_data = '0; ifa.host_ready = 0;
    ifb.out_valid = 0; ifb.out_data = '0; ifb.host_ready = 0;
    ifc.out_valid = 0; ifc.out_data = '0; ifc.host_ready = 0;
    pf_a = 0; pf_b = 0; pf_c = 0;
`ifdef OUT_CHANNEL_COMPARE_EN
    exp_data_a = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset mid-run discards the buffered word.
    ifa.out_valid = 1; ifa.out_data = 12'd9;
    tick();
    chk("pre_rst hv", ifa.host_valid, 1);
    chk("pre_rst wt", wt_a, 1);
    ifa.out_valid = 0;
    reset = 1'b1;
    tick();
    chk("rst ordy", ifa.out_ready, 1);
    chk("rst hv", ifa.host_valid, 0);
    chk("rst wt", wt_a, 0);
    chk("rst ovf", ovf_a, 0);
    chk("rst fin", fin_a, 0);
    chk("rst suc", suc_a, 0);
    reset = 1'b0;

    // Apply the vector table to dut_a.
    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst) pulse_reset();
      ifa.out_valid = vt[i].ov; ifa.out_data = vt[i].od;
      ifa.host_ready = vt[i].hr; pf_a = vt[i].pf;
`ifdef OUT_CHANNEL_COMPARE_EN
      exp_data_a = vt[i].od;
`endif
      tick();
      chk($sformatf("v%0d ordy", i), ifa.out_ready, vt[i].e_ordy);
      chk($sformatf("v%0d hv", i), ifa.host_valid, vt[i].e_hv);
      if (vt[i].chk_hd) chk($sformatf("v%0d hd", i), ifa.host_data, vt[i].e_hd);
      chk($sformatf("v%0d wt", i), wt_a, vt[i].e_wt);
      chk($sformatf("v%0d ovf", i), ovf_a, vt[i].e_ovf);
      chk($sformatf("v%0d fin", i), fin_a, vt[i].e_fin);
      chk($sformatf("v%0d suc", i), suc_a, vt[i].e_suc);
    end
    ifa.out_valid = 0; ifa.host_ready = 0; pf_a = 0;

    // dut_b: fill the 4-deep buffer, offer a fifth word, then pop to make room.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      ifb.out_valid = 1; ifb.out_data = word_t'(i + 1);
      tick();
      chk($sformatf("fill%0d wt", i), wt_b, i + 1);
      chk($sformatf("fill%0d ordy", i), ifb.out_ready, (i < 3) ? 1 : 0);
    end
    ifb.out_data = 12'd5;
    tick();
    chk("full ovf", ovf_b, 1);
    chk("full wt", wt_b, 4);
    chk("full ordy", ifb.out_ready, 0);
    chk("full hd", ifb.host_data, 1);
    ifb.host_ready = 1;
    tick();
    chk("pop_room ordy", ifb.out_ready, 1);
    chk("pop_room wt", wt_b, 4);
    chk("pop_room hd", ifb.host_data, 2);
    ifb.host_ready = 0;
    tick();
    chk("refill wt", wt_b, 5);
    chk("refill ordy", ifb.out_ready, 0);
    ifb.out_valid = 0;

    // dut_b: push 7, then push 8 in the same cycle as finishing, then drain.
    pulse_reset();
    ifb.out_valid = 1; ifb.out_data = 12'd7;
    tick();
    chk("d7 wt", wt_b, 1);
    ifb.out_data = 12'd8; pf_b = 1;
    tick();
    chk("d8 wt", wt_b, 2);
    chk("d8 ordy", ifb.out_ready, 0);
    chk("d8 hd", ifb.host_data, 7);
    chk("d8 fin", fin_b, 0);
    ifb.out_valid = 0; pf_b = 0; ifb.host_ready = 1;
    tick();
    chk("pop7 hd", ifb.host_data, 8);
    chk("pop7 fin", fin_b, 0);
    tick();
    chk("pop8 fin", fin_b, 1);
    chk("pop8 suc", suc_b, 1);
    chk("pop8 hv", ifb.host_valid, 0);
    ifb.host_ready = 0;
    tick();
    chk("hold fin", fin_b, 1);
    chk("hold suc", suc_b, 1);

`ifdef OUT_CHANNEL_COMPARE_EN
    // dut_a: the word pushed differs from the expected word.
    pulse_reset();
    exp_data_a = 12'd1;
    ifa.out_valid = 1; ifa.out_data = 12'd2;
    tick();
    chk("cmp mm", mm_a, 1);
    chk("cmp fb", fb_a, 0);
    chk("cmp ei", ei_a, 1);
    ifa.out_valid = 0; pf_a = 1;
    tick();
    pf_a = 0; ifa.host_ready = 1;
    tick();
    chk("cmp fin", fin_a, 1);
    chk("cmp suc", suc_a, 0);
    ifa.host_ready = 0;
`endif

    // dut_c: a 3-deep buffer pushed and popped through pointer wrap, checked against a queue model.
    pulse_reset();
    m_wt = 0; m_ovf = 0;
    for (int i = 0; i < 10; i++) begin
      ifc.out_valid = 1; ifc.out_data = word_t'(100 + i);
      ifc.host_ready = (i % 3 != 0);
      do_push = (model_q.size() < 3);
      do_pop  = (model_q.size() > 0) && ifc.host_ready;
      if (model_q.size() == 3) m_ovf = 1;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(word_t'(100 + i));
        m_wt++;
      end
      tick();
      chk($sformatf("w%0d hv", i), ifc.host_valid, (model_q.size() > 0) ? 1 : 0);
      if (model_q.size() > 0) chk($sformatf("w%0d hd", i), ifc.host_data, model_q[0]);
      chk($sformatf("w%0d ordy", i), ifc.out_ready, (model_q.size() < 3) ? 1 : 0);
      chk($sformatf("w%0d wt", i), wt_c, m_wt);
      chk($sformatf("w%0d ovf", i), ovf_c, m_ovf);
    end
    ifc.out_valid = 0; ifc.host_ready = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
